register_tree_kv: RTL
=====================

REGISTER_TREE_KV -- requirements
Module: register_tree_kv

Interface
REQ-001 SHALL have parameter QUEUE_SIZE, default 15, max valid entries held (>=1).
REQ-002 SHALL have parameter KEY_WIDTH, default 16, priority key width.
REQ-003 SHALL have parameter PAYLOAD_WIDTH, default 8, payload width carried with each key.
REQ-004 SHALL have parameter MIN_MODE, default 0, 0 = max-priority at root, 1 = min-priority at root.
REQ-005 SHALL have port i_CLK  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port i_RSTn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_wrt  input  1  enqueue request (replace when i_read also high).
REQ-008 SHALL have port i_read  input  1  dequeue request (replace when i_wrt also high).
REQ-009 SHALL have port i_key  input  KEY_WIDTH  key to insert.
REQ-010 SHALL have port i_payload  input  PAYLOAD_WIDTH  payload to insert.
REQ-011 SHALL have port o_full  output  1  high when o_count == QUEUE_SIZE.
REQ-012 SHALL have port o_empty  output  1  high when o_count == 0.
REQ-013 SHALL have port o_valid  output  1  root node valid.
REQ-014 SHALL have port o_key  output  KEY_WIDTH  root key, 0 when root invalid.
REQ-015 SHALL have port o_payload  output  PAYLOAD_WIDTH  root payload, 0 when root invalid.
REQ-016 SHALL have port o_count  output  $clog2(QUEUE_SIZE+1)  number of valid entries.

Function
REQ-017 SHALL hold N = 2^ceil(log2(QUEUE_SIZE+1)) - 1 nodes, each {valid, key, payload}, in heap order: node i has children 2i+1, 2i+2.
REQ-018 SHALL define emptiness by per-node valid bit only; key value 0 is a legal key.
REQ-019 SHALL define "A beats B": A valid and (B invalid, or key_A > key_B when MIN_MODE=0, key_A < key_B when MIN_MODE=1); equal keys do not beat.
REQ-020 SHALL decode the operation each cycle as follows: i_wrt & !i_read = ENQ; !i_wrt & i_read = DEQ; both high = REP; neither high = SWAP.
REQ-021 ENQ when !o_full SHALL write {1, i_key, i_payload} to the lowest-index invalid node and increment o_count; ENQ when full SHALL leave all state unchanged.
REQ-022 DEQ when !o_empty SHALL clear root valid (key/payload to 0) and decrement o_count; DEQ when empty SHALL leave all state unchanged.
REQ-023 REP when root valid SHALL overwrite root {key, payload} with o_count unchanged; REP when root invalid SHALL write the root valid and increment o_count, unless o_full, in which case state is unchanged.
REQ-024 SWAP SHALL, within one cycle, apply compare-exchange to every parent on even levels (0, 2, ...), then to every parent on odd levels using the even-phase result; leaf level is never a parent.
REQ-025 Compare-exchange SHALL swap the parent with the winning child when that child beats the parent; left wins over right unless right beats left; key, payload and valid move together.
REQ-026 ENQ, DEQ and REP cycles SHALL perform no compare-exchange.
REQ-027 Outputs SHALL be registered-state decodes: o_key/o_payload/o_valid reflect the root register, zero-latency after the updating edge.
REQ-028 o_count SHALL never exceed QUEUE_SIZE nor underflow below 0.
REQ-029 A single valid entry SHALL reach the root within ceil(depth/2) SWAP cycles of a DEQ or REP, where depth = log2(N+1); the user is responsible for idle cycles before trusting o_key.

Reset
REQ-030 When i_RSTn is low at a rising edge, all node valid/key/payload bits and o_count SHALL be 0, overriding any simultaneous i_wrt/i_read.
REQ-031 After reset: o_empty=1, o_full=0, o_valid=0, o_key=0, o_payload=0, o_count=0.

Verification (QUEUE_SIZE=7, KEY_WIDTH=8, PAYLOAD_WIDTH=4, MIN_MODE=0 unless stated)
REQ-032 Reset: hold i_RSTn=0 two cycles with i_wrt=1 -> o_empty=1, o_count=0, o_valid=0, o_key=0.
REQ-033 Ordering: ENQ keys 3,9,5 (payload 1,2,3) back-to-back, one SWAP cycle -> o_key=9, o_payload=2, o_count=3; DEQ, two SWAP cycles -> o_key=5, o_payload=3, o_count=2.
REQ-034 Full: ENQ keys 1..7, then ENQ key 8 -> o_full=1, o_count=7, key 8 never appears at root after 3 SWAP cycles (o_key=7); REP key 0 -> o_count=7.
REQ-035 Zero key: from empty, ENQ key 0 payload 5 -> o_empty=0, o_valid=1, o_key=0, o_payload=5, o_count=1; DEQ on empty afterwards twice -> o_count=0 and remains 0.
REQ-036 Min mode: MIN_MODE=1, ENQ keys 4,1,7, one SWAP cycle -> o_key=1; REP key 9, two SWAP cycles -> o_key=4, o_count=3.
REQ-037 Reset mid-operation: with 3 entries held, drive i_wrt=i_read=1 and i_RSTn=0 same edge -> next cycle o_count=0, o_valid=0, o_empty=1.

Source files
------------

// File: rtl/register_tree_kv.sv
// Register-tree priority queue: root holds best {key,payload}; heap sorted by background compare-exchange sweeps.
// Latency: enqueue/dequeue/replace take effect at the next edge; an idle cycle runs one even-then-odd sort sweep.
// Backpressure: none; enqueue when full and dequeue when empty are ignored, so o_count stays within range.
module register_tree_kv #(
    parameter int QUEUE_SIZE    = 15,
    parameter int KEY_WIDTH     = 16,
    parameter int PAYLOAD_WIDTH = 8,
    parameter int MIN_MODE      = 0
) (
    input  logic                             i_CLK,
    input  logic                             i_RSTn,
    input  logic                             i_wrt,
    input  logic                             i_read,
    input  logic [KEY_WIDTH-1:0]             i_key,
    input  logic [PAYLOAD_WIDTH-1:0]         i_payload,
    output logic                             o_full,
    output logic                             o_empty,
    output logic                             o_valid,
    output logic [KEY_WIDTH-1:0]             o_key,
    output logic [PAYLOAD_WIDTH-1:0]         o_payload,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]  o_count
);

    localparam int DEPTH   = $clog2(QUEUE_SIZE + 1);
    localparam int NODES   = (1 << DEPTH) - 1;
    localparam int PARENTS = (NODES - 1) / 2;
    localparam int CW      = $clog2(QUEUE_SIZE + 1);

    typedef struct packed {
        logic                     vld;
        logic [KEY_WIDTH-1:0]     key;
        logic [PAYLOAD_WIDTH-1:0] pay;
    } node_t;

    typedef struct packed {
        node_t par;
        node_t lft;
        node_t rgt;
    } tri_t;

    // Bit i set when node i sits on an even tree level (root is level 0).
    function automatic logic [NODES-1:0] calc_even_mask();
        logic [NODES-1:0] m;
        int               lvl;
        m = '0;
        for (int i = 0; i < NODES; i++) begin
            lvl = 0;
            for (int b = 1; b < 32; b++) begin
                if (((i + 1) >> b) != 0) lvl = b;
            end
            m[i] = ((lvl % 2) == 0);
        end
        return m;
    endfunction

    localparam logic [NODES-1:0] EVEN_MASK = calc_even_mask();

    // A beats B: A valid and either B empty or A's key strictly better; ties never beat.
    function automatic logic beats(node_t a, node_t b);
        logic better;
        if (MIN_MODE != 0) better = (a.key < b.key);
        else               better = (a.key > b.key);
        return a.vld && (!b.vld || better);
    endfunction

    // One parent/children compare-exchange; left child is preferred unless right strictly beats it.
    function automatic tri_t cmp_xchg(node_t par, node_t lft, node_t rgt);
        tri_t r;
        r.par = par;
        r.lft = lft;
        r.rgt = rgt;
        if (beats(rgt, lft)) begin
            if (beats(rgt, par)) begin
                r.par = rgt;
                r.rgt = par;
            end
        end else if (beats(lft, par)) begin
            r.par = lft;
            r.lft = par;
        end
        return r;
    endfunction

    node_t           heap_q [NODES];
    node_t           heap_d [NODES];
    node_t           sw     [NODES];
    tri_t            cx;
    node_t           new_node;
    int              free_idx;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            full;
    logic            empty;

    assign new_node = '{vld: 1'b1, key: i_key, pay: i_payload};
    assign full     = (cnt_q == CW'(QUEUE_SIZE));
    assign empty    = (cnt_q == '0);

    // Sort sweep: all even-level parents exchange first, then odd-level parents see that result.
    always_comb begin
        cx = '0;
        for (int n = 0; n < NODES; n++) sw[n] = heap_q[n];
        for (int ph = 0; ph < 2; ph++) begin
            for (int p = 0; p < PARENTS; p++) begin
                if (EVEN_MASK[p] == (ph == 0)) begin
                    cx          = cmp_xchg(sw[p], sw[2*p+1], sw[2*p+2]);
                    sw[p]       = cx.par;
                    sw[2*p+1]   = cx.lft;
                    sw[2*p+2]   = cx.rgt;
                end
            end
        end
    end

    // Lowest-index empty node is where a new entry lands.
    always_comb begin
        free_idx = 0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (!heap_q[i].vld) free_idx = i;
        end
    end

    // Operation decode: enqueue, dequeue, replace-root, or an idle sort sweep.
    always_comb begin
        for (int n = 0; n < NODES; n++) heap_d[n] = heap_q[n];
        cnt_d = cnt_q;
        case ({i_wrt, i_read})
            2'b10: begin
                if (!full) begin
                    heap_d[free_idx] = new_node;
                    cnt_d            = cnt_q + CW'(1);
                end
            end
            2'b01: begin
                if (!empty) begin
                    heap_d[0] = '0;
                    cnt_d     = cnt_q - CW'(1);
                end
            end
            2'b11: begin
                if (heap_q[0].vld) begin
                    heap_d[0] = new_node;
                end else if (!full) begin
                    heap_d[0] = new_node;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            default: begin
                for (int n = 0; n < NODES; n++) heap_d[n] = sw[n];
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority over any request.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            for (int n = 0; n < NODES; n++) heap_q[n] <= '0;
            cnt_q <= '0;
        end else begin
            for (int n = 0; n < NODES; n++) heap_q[n] <= heap_d[n];
            cnt_q <= cnt_d;
        end
    end

    assign o_full    = full;
    assign o_empty   = empty;
    assign o_valid   = heap_q[0].vld;
    assign o_key     = heap_q[0].vld ? heap_q[0].key : '0;
    assign o_payload = heap_q[0].vld ? heap_q[0].pay : '0;
    assign o_count   = cnt_q;

endmodule
